// File: rtl/rr_dec_arb_pkg.sv
// rr_dec_arb_pkg: shared sizes, FSM state type and the find-first helper for the round-robin arbiter
package rr_dec_arb_pkg;
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 5;
   typedef enum logic {IDLE, GRANT} state_t;
   // lowest set bit wins; returns 0 for an all-zero vector
   function automatic logic [IDX_W-1:0] find_first(input logic [NUM_REQ-1:0] v);
      find_first = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (v[i]) find_first = IDX_W'(i);
   endfunction
endpackage

// File: rtl/rr_dec_arbiter_if.sv
// rr_dec_arbiter_if: request/release inputs and grant outputs of the round-robin arbiter
interface rr_dec_arbiter_if;
   import rr_dec_arb_pkg::*;
   logic               en;
   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               timeout;
   modport master (output en, req, done, input gnt, gnt_idx, gnt_valid, timeout);
   modport slave  (input en, req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_dec_arbiter_dec3to8_en.sv
// dec3to8_en: combinational 3-to-8 one-hot decoder, all-zero when disabled
module dec3to8_en
   import rr_dec_arb_pkg::*;
(
   input  logic               en_i,
   input  logic [IDX_W-1:0]   idx_i,
   output logic [NUM_REQ-1:0] y_o
);
   assign y_o = en_i ? NUM_REQ'(1) << idx_i : '0;
endmodule

// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: 8-way round-robin arbiter with registered one-hot grant; RR_DEC_ARB_TIMEOUT_EN adds a MAX_HOLD forced release
module rr_dec_arbiter
   import rr_dec_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input logic clk,
   input logic rst_n,
   rr_dec_arbiter_if.slave arb
);
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d, win;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, rot;
   logic               valid_q, valid_d, to_q, to_d, expire, cause, release_c;
   assign cause     = arb.done | ~arb.req[idx_q] | ~arb.en;
   assign release_c = cause | expire;
`ifdef RR_DEC_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d  = (state_q == GRANT && !release_c) ? cnt_q + 1'b1 : '0;
   assign expire = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
   // hold counter: zero on grant entry, counts each cycle the grant is kept
   always_ff @(posedge clk) begin
      cnt_q <= !rst_n ? '0 : cnt_d;
   end
`else
   assign expire = (MAX_HOLD < 0);
`endif
   // next state: rotate requests by ptr, pick first, un-rotate; release on any cause
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      to_d    = 1'b0;
      rot     = '0;
      for (int i = 0; i < NUM_REQ; i++) rot[i] = arb.req[ptr_q + IDX_W'(i)];
      win = ptr_q + find_first(rot);
      if (state_q == IDLE) begin
         if (arb.en && |arb.req) begin
            state_d = GRANT;
            idx_d   = win;
            valid_d = 1'b1;
            ptr_d   = win + 1'b1;
         end
      end else if (release_c) begin
         state_d = IDLE;
         idx_d   = '0;
         valid_d = 1'b0;
         to_d    = expire & ~cause;
      end
   end
   dec3to8_en u_dec (.en_i(valid_d), .idx_i(idx_d), .y_o(gnt_d));
   // state and registered grant outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         gnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         gnt_q   <= gnt_d;
         to_q    <= to_d;
      end
   end
   assign arb.gnt       = gnt_q;
   assign arb.gnt_idx   = idx_q;
   assign arb.gnt_valid = valid_q;
   assign arb.timeout   = to_q;
endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb_rr_dec_arbiter: directed stimulus with a grant scoreboard checked by an independent monitor
module tb_rr_dec_arbiter;
   typedef struct {
      logic [2:0] idx;
      int         len;
      logic       to;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   exp_t cur;
   int   cur_len = 0;
   logic prev_v = 1'b0;
   rr_dec_arbiter_if arb ();
   rr_dec_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .arb(arb));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   function automatic void push(input int idx, input int len, input bit to);
      exp_t e;
      e.idx = 3'(idx);
      e.len = len;
      e.to  = to;
      sbq.push_back(e);
   endfunction
   always @(negedge clk) begin
      chk("onehot", {24'h0, arb.gnt}, arb.gnt_valid ? 32'(8'h01 << arb.gnt_idx) : 32'h0);
      if (!(prev_v && !arb.gnt_valid)) chk("timeout_quiet", {31'h0, arb.timeout}, 32'h0);
      if (arb.gnt_valid && !prev_v) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant got idx=%0d expected no grant at %0t", arb.gnt_idx, $time);
            cur.idx = arb.gnt_idx;
            cur.len = -1;
            cur.to  = 1'b0;
         end else begin
            cur = sbq.pop_front();
            chk("grant_idx", {29'h0, arb.gnt_idx}, {29'h0, cur.idx});
         end
         cur_len = 1;
      end else if (arb.gnt_valid) begin
         cur_len++;
      end else if (prev_v) begin
         chk("grant_len", cur_len, cur.len);
         chk("timeout_pulse", {31'h0, arb.timeout}, {31'h0, cur.to});
      end
      prev_v = arb.gnt_valid;
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 1'b0;
      arb.en = 1'b0;
      arb.req = 8'h00;
      arb.done = 1'b0;
      step(2);
      chk("rst_gnt", {24'h0, arb.gnt}, 32'h0);
      chk("rst_idx", {29'h0, arb.gnt_idx}, 32'h0);
      chk("rst_valid", {31'h0, arb.gnt_valid}, 32'h0);
      chk("rst_timeout", {31'h0, arb.timeout}, 32'h0);
      // single requester, done in the third grant cycle
      rst_n = 1'b1;
      arb.en = 1'b1;
      arb.req = 8'h01;
      push(0, 3, 0);
      step(3);
      arb.done = 1'b1;
      arb.req = 8'h00;
      step(1);
      arb.done = 1'b0;
      chk("rel_zero", {24'h0, arb.gnt}, 32'h0);
      // full rotation from a fresh pointer, wraps 7 -> 0
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      arb.req = 8'hFF;
      arb.done = 1'b1;
      for (int i = 0; i < 9; i++) push(i % 8, 1, 0);
      step(17);
      arb.req = 8'h00;
      arb.done = 1'b0;
      step(1);
      // move pointer to 3 by granting idx 2
      arb.req = 8'h04;
      arb.done = 1'b1;
      push(2, 1, 0);
      step(1);
      arb.req = 8'h00;
      arb.done = 1'b0;
      step(1);
      // req 8'h84 with ptr 3: idx 7 then idx 2
      arb.req = 8'h84;
      push(7, 2, 0);
      push(2, 2, 0);
      step(2);
      arb.done = 1'b1;
      step(1);
      arb.done = 1'b0;
      step(2);
      arb.done = 1'b1;
      arb.req = 8'h00;
      step(1);
      arb.done = 1'b0;
      // enable drop mid-grant, then re-grant after one idle cycle
      arb.req = 8'h08;
      push(3, 2, 0);
      step(2);
      arb.en = 1'b0;
      step(1);
      chk("en_drop_zero", {24'h0, arb.gnt}, 32'h0);
      arb.en = 1'b1;
      push(3, 1, 0);
      step(1);
      arb.done = 1'b1;
      arb.req = 8'h00;
      step(1);
      arb.done = 1'b0;
      arb.req = 8'h10;
`ifdef RR_DEC_ARB_TIMEOUT_EN
      push(4, 4, 1);
      push(4, 4, 0);
      step(9);
      arb.done = 1'b1;
      step(1);
`else
      push(4, 20, 0);
      step(20);
      arb.done = 1'b1;
      step(1);
`endif
      arb.done = 1'b0;
      arb.req = 8'h00;
      step(1);
      // reset during grant of idx 5, then idx 0 beats idx 5
      arb.req = 8'h20;
      push(5, 2, 0);
      step(2);
      rst_n = 1'b0;
      step(1);
      chk("rst_mid_gnt", {24'h0, arb.gnt}, 32'h0);
      chk("rst_mid_valid", {31'h0, arb.gnt_valid}, 32'h0);
      chk("rst_mid_idx", {29'h0, arb.gnt_idx}, 32'h0);
      rst_n = 1'b1;
      arb.req = 8'h21;
      push(0, 1, 0);
      step(1);
      arb.done = 1'b1;
      arb.req = 8'h00;
      step(1);
      arb.done = 1'b0;
      step(2);
      chk("sb_empty", sbq.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_dec_arbiter.md
# rr_dec_arbiter

Round-robin arbiter sharing one 8-way resource slot among eight requesters. It selects one requester, holds the grant until release, and drives the one-hot select through a registered 3-to-8 decoder with enable. It sits in front of the decoder-selected datapath as its sequencer, so exactly one consumer line is active at a time.

## Interface
- MAX_HOLD, 16, maximum grant cycles before forced release (only used with timeout compiled in); legal range 2..31
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  global enable; low blocks new grants and revokes the current one
- req  in  8  request lines, bit i = requester i, level-sensitive
- done  in  1  release strobe from the current grant holder
- gnt  out  8  one-hot grant, registered; all-zero when no grant
- gnt_idx  out  3  binary index of granted requester; 0 when no grant
- gnt_valid  out  1  high while a grant is held
- timeout  out  1  one-cycle pulse on forced release

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if en=1 and req!=0, select a winner by round-robin from pointer ptr; search ptr, ptr+1, ... mod 8; first set bit wins. Go to GRANT; latch gnt_idx=winner, gnt=decode(winner), gnt_valid=1; ptr<=winner+1 mod 8.
- IDLE with en=0 or req=0: stay; outputs zero.
- GRANT: release when any of: done=1; req[gnt_idx]=0; en=0; timeout (if compiled). On release go to IDLE; gnt, gnt_idx and gnt_valid go to 0.
- done is only valid in GRANT; ignored in IDLE.
- Simultaneous release conditions: single release; timeout pulses only when the counter expiry is the sole cause (done and req-drop take precedence).
- Requests arriving during GRANT are held pending by the requester (level); no internal queueing.
- ptr wrap: winner 7 -> ptr 0.

## Timing
- Reset: state=IDLE, ptr=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0, hold counter=0. Requester 0 has highest priority after reset.
- Grant latency: req sampled in IDLE at edge N -> gnt valid after edge N (visible in cycle N+1).
- Release: condition sampled at edge M -> gnt zero after edge M.
- One mandatory IDLE bubble cycle between consecutive grants; back-to-back grant to the same or another requester takes ≥2 cycles.
- Reset asserted mid-grant: outputs clear at the next edge regardless of done/req; ptr returns to 0.
- gnt is always one-hot or zero; never multi-hot.

## Configuration
- RR_DEC_ARB_TIMEOUT_EN defined: 5-bit hold counter clears on entry to GRANT and increments each GRANT cycle; when the counter reaches MAX_HOLD-1 with no other release cause, force release at that edge and pulse timeout for one cycle. The grant therefore lasts exactly MAX_HOLD cycles.
- Not defined: no counter; grant is held indefinitely until done, req drop or en=0; timeout tied 0.

## Structure
- Package rr_dec_arb_pkg: NUM_REQ=8, IDX_W=3, CNT_W=5, and the state enum {IDLE, GRANT}.
- Sub-module dec3to8_en: combinational 3-to-8 one-hot decoder with enable (en=0 -> 8'h00). Its output is registered in the arbiter.
- Priority search is implemented as a rotate-by-ptr, fixed-priority find-first, then un-rotate; it stays in the top level.

## Test plan
- Reset, then req=8'h01, done at 3rd grant cycle -> gnt=8'h01, gnt_idx=0 one cycle after req; zero after the done edge; ptr=1.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0 with one idle bubble between grants; wraps from 7 to 0.
- req=8'h84 with ptr=3 -> gnt=8'h80 (idx 7) first, then idx 2 after release.
- Mid-grant en=0 -> gnt=8'h00 next cycle; re-raise en with the same req -> new grant after one IDLE cycle.
- With RR_DEC_ARB_TIMEOUT_EN and MAX_HOLD=4, req=8'h10 held, no done -> gnt=8'h10 for exactly 4 cycles, then a timeout pulse and 1 idle cycle, then re-grant. Repeat with done asserted on the 4th cycle -> no timeout pulse.
- rst_n low during grant of idx 5 -> all outputs zero after the edge; next request from idx 0 and idx 5 together -> idx 0 wins.
